// File: rtl/mux_arb_pkg.sv
// Shared types and round-robin helper for the 4-requester mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   last_ptr);
    pick_t            pick;
    logic [SEL_W-1:0] idx;
    pick = '0;
    // Walk farthest-first so the nearest set bit after last_ptr is the one that sticks.
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last_ptr + SEL_W'(i);
      if (req[idx]) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_data.sv
// Combinational 4:1 mux built as two 2:1 stages; zero latency, no flow control.
module mux4_data
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [NUM_REQ*DATA_W-1:0] in_dat,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         out_dat
);

  logic [DATA_W-1:0] lo_dat;
  logic [DATA_W-1:0] hi_dat;

  assign lo_dat  = sel[0] ? in_dat[DATA_W   +: DATA_W] : in_dat[0        +: DATA_W];
  assign hi_dat  = sel[0] ? in_dat[3*DATA_W +: DATA_W] : in_dat[2*DATA_W +: DATA_W];
  assign out_dat = sel[1] ? hi_dat : lo_dat;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux; grant one cycle after req, one bubble between packets.
// Backpressure: out_ready passes straight to the granted in_ready; a stalled beat is held as-is.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_last,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_BEATS - 1);

  state_t            state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [DATA_W-1:0] mux_dat;
  logic              mux_vld;
  logic              mux_last;
  logic              limit_hit;
  logic              accept;
  pick_t             pick;

  mux4_data #(.DATA_W(DATA_W)) u_data (.in_dat(in_data),  .sel(sel_q), .out_dat(mux_dat));
  mux4_data #(.DATA_W(1))      u_vld  (.in_dat(in_valid), .sel(sel_q), .out_dat(mux_vld));
  mux4_data #(.DATA_W(1))      u_last (.in_dat(in_last),  .sel(sel_q), .out_dat(mux_last));

  assign busy      = (state_q == ST_BUSY);
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign limit_hit = (MAX_BEATS != 0) && (beat_cnt_q == BEAT_LIMIT);
  assign out_valid = busy & mux_vld;
  assign out_last  = busy & (mux_last | limit_hit);
  assign out_data  = busy ? mux_dat : '0;
  // grant_q is already one-hot of sel_q and is zero outside BUSY.
  assign in_ready  = out_ready ? grant_q : '0;
  assign accept    = out_valid & out_ready;
  assign pick      = rr_pick(req, last_ptr_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          state_d    = ST_BUSY;
          sel_d      = pick.idx;
          grant_d    = NUM_REQ'(1) << pick.idx;
          beat_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
          if (out_last) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            last_ptr_d = sel_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_ptr_q <= SEL_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter built with a 4-beat release limit.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        busy;

  logic [7:0]  d [4];
  int          n_assert;
  int          n_fail;

  assign in_data = {d[3], d[2], d[1], d[0]};

  mux4_rr_arbiter #(.DATA_W(8), .MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      8'(busy),      8'h0);
    check({tag, "_grant"},     8'(grant),     8'h0);
    check({tag, "_out_valid"}, 8'(out_valid), 8'h0);
    check({tag, "_out_last"},  8'(out_last),  8'h0);
    check({tag, "_out_data"},  out_data,      8'h00);
    check({tag, "_in_ready"},  8'(in_ready),  8'h0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    d[0] = 8'h10; d[1] = 8'h20; d[2] = 8'h30; d[3] = 8'h40;

    // Reset with every input active: outputs must still be quiet.
    @(posedge clk);
    @(posedge clk);
    #2;
    check_idle("rst");
    check("rst_sel", 8'(sel), 8'h0);

    tick();
    rst_n = 1'b1;
    #1;

    // Test 1: all request, 1-beat packets; grants 0,1,2,3,0 (0001, 0010, 0100, 1000, 0001).
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("t1_grant",    8'(grant),     8'(1 << (k % 4)));
      check("t1_busy",     8'(busy),      8'h1);
      check("t1_out_data", out_data,      8'(8'h10 * ((k % 4) + 1)));
      check("t1_out_last", 8'(out_last),  8'h1);
      tick();
      #1;
      check_idle("t1_bubble");
    end

    // Test 2: requester 2, three beats at full rate.
    req = 4'b0100; in_valid = 4'b0100; in_last = 4'b0000;
    d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'hA1; d[3] = 8'h00;
    tick();
    req = 4'b0000;
    #1;
    check("t2_grant",    8'(grant),    8'h4);
    check("t2_sel",      8'(sel),      8'h2);
    check("t2_data1",    out_data,     8'hA1);
    check("t2_in_ready", 8'(in_ready), 8'h4);
    check("t2_last1",    8'(out_last), 8'h0);
    tick();
    d[2] = 8'hA2;
    #1;
    check("t2_data2",    out_data,     8'hA2);
    check("t2_last2",    8'(out_last), 8'h0);
    tick();
    d[2] = 8'hA3; in_last = 4'b0100;
    #1;
    check("t2_data3",    out_data,     8'hA3);
    check("t2_last3",    8'(out_last), 8'h1);
    check("t2_busy3",    8'(busy),     8'h1);
    tick();
    #1;
    check_idle("t2_end");

    // Test 3: requester 2 again, downstream stalls on beat 2.
    req = 4'b0100; in_valid = 4'b0100; in_last = 4'b0000; d[2] = 8'hB1;
    tick();
    #1;
    check("t3_grant",    8'(grant),    8'h4);
    check("t3_data1",    out_data,     8'hB1);
    check("t3_rdy1",     8'(in_ready), 8'h4);
    tick();
    d[2] = 8'hB2; out_ready = 1'b0;
    #1;
    check("t3_stall_vld",  8'(out_valid), 8'h1);
    check("t3_stall_data", out_data,      8'hB2);
    check("t3_stall_rdy",  8'(in_ready),  8'h0);
    tick();
    #1;
    check("t3_hold_data",  out_data,      8'hB2);
    check("t3_hold_rdy",   8'(in_ready),  8'h0);
    check("t3_hold_busy",  8'(busy),      8'h1);
    tick();
    out_ready = 1'b1;
    #1;
    check("t3_resume_rdy",  8'(in_ready), 8'h4);
    check("t3_resume_data", out_data,     8'hB2);
    check("t3_resume_last", 8'(out_last), 8'h0);
    tick();
    d[2] = 8'hB3; in_last = 4'b0100;
    #1;
    check("t3_data3",    out_data,     8'hB3);
    check("t3_last3",    8'(out_last), 8'h1);
    tick();
    #1;
    check_idle("t3_end");

    // Test 4: requester 1 sends 6 beats; limit of 4 forces a release after beat 4.
    req = 4'b0010; in_valid = 4'b0010; in_last = 4'b0000;
    d[2] = 8'h00; d[1] = 8'hC1;
    tick();
    #1;
    check("t4_grant",  8'(grant),    8'h2);
    check("t4_data1",  out_data,     8'hC1);
    check("t4_last1",  8'(out_last), 8'h0);
    for (int b = 2; b <= 4; b++) begin
      tick();
      d[1] = 8'(8'hC0 + b);
      #1;
      check("t4_data", out_data,     8'(8'hC0 + b));
      check("t4_last", 8'(out_last), 8'(b == 4));
    end
    tick();
    d[1] = 8'hC5;
    #1;
    check_idle("t4_forced");
    tick();
    #1;
    check("t4_regrant", 8'(grant),    8'h2);
    check("t4_data5",   out_data,     8'hC5);
    check("t4_last5",   8'(out_last), 8'h0);
    tick();
    d[1] = 8'hC6; in_last = 4'b0010;
    #1;
    check("t4_data6",   out_data,     8'hC6);
    check("t4_last6",   8'(out_last), 8'h1);
    tick();
    req = 4'b0000; in_valid = 4'b0000; in_last = 4'b0000;
    #1;
    check_idle("t4_end");

    // Test 5: reset while beat 2 of 3 from requester 0 is pending.
    req = 4'b0001; in_valid = 4'b0001; d[1] = 8'h00; d[0] = 8'hD1;
    tick();
    #1;
    check("t5_grant",   8'(grant), 8'h1);
    check("t5_data1",   out_data,  8'hD1);
    tick();
    d[0] = 8'hD2; out_ready = 1'b0;
    #1;
    check("t5_pend_data", out_data,      8'hD2);
    check("t5_pend_vld",  8'(out_valid), 8'h1);
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    check_idle("t5_rst");
    check("t5_rst_sel", 8'(sel), 8'h0);
    tick();
    rst_n = 1'b1; req = 4'b1111; in_valid = 4'b0001; in_last = 4'b0001; d[0] = 8'hE1;
    #1;
    check("t5_idle_busy", 8'(busy), 8'h0);
    tick();
    #1;
    check("t5_first_grant", 8'(grant),    8'h1);
    check("t5_first_sel",   8'(sel),      8'h0);
    check("t5_first_data",  out_data,     8'hE1);
    check("t5_first_last",  8'(out_last), 8'h1);
    tick();
    req = 4'b0000;
    #1;
    check_idle("t5_end");

    // Test 6: requester 3 owns the mux; requester 0 asserts valid and req but never leaks through.
    req = 4'b1000; in_valid = 4'b1001; in_last = 4'b0001;
    d[0] = 8'hEE; d[3] = 8'hF1;
    tick();
    req = 4'b0001;
    #1;
    check("t6_grant",    8'(grant),    8'h8);
    check("t6_data1",    out_data,     8'hF1);
    check("t6_last1",    8'(out_last), 8'h0);
    check("t6_rdy1",     8'(in_ready), 8'h8);
    tick();
    d[3] = 8'hF2; in_valid = 4'b0001;
    #1;
    check("t6_gap_vld",   8'(out_valid), 8'h0);
    check("t6_gap_grant", 8'(grant),     8'h8);
    check("t6_gap_rdy",   8'(in_ready),  8'h8);
    check("t6_gap_data",  out_data,      8'hF2);
    tick();
    in_valid = 4'b1001; in_last = 4'b1001;
    #1;
    check("t6_data2",    out_data,      8'hF2);
    check("t6_vld2",     8'(out_valid), 8'h1);
    check("t6_last2",    8'(out_last),  8'h1);
    tick();
    #1;
    check_idle("t6_end");
    tick();
    #1;
    check("t6_next_grant", 8'(grant), 8'h1);
    check("t6_next_data",  out_data,  8'hEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
